pong_game_ctrl: RTL

- Top-level game sequencer for the Pong ball datapath.
- Decides when the ball is held at centre, when it is served and in which diagonal direction, and when it moves.
- Detects goals from the ball column, keeps both scores, and declares the winner.
- Sits between the player buttons and the ball mover; drives its load/enable/direction controls.

---
 rtl/pong_pkg.sv | 25 ++
 rtl/pong_game_ctrl_if.sv | 31 +++
 rtl/pong_edge_detect.sv | 23 ++
 rtl/pong_game_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong game sequencer: state encodings, serve directions
// and default playfield geometry.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SERVE_WAIT = 3'd1,
        ST_PLAY       = 3'd2,
        ST_PAUSED     = 3'd3,
        ST_POINT      = 3'd4,
        ST_GAME_OVER  = 3'd5
    } state_e;

    // serve_dir is {right, down}
    localparam logic [1:0] UP_LEFT    = 2'b00;
    localparam logic [1:0] DOWN_LEFT  = 2'b01;
    localparam logic [1:0] UP_RIGHT   = 2'b10;
    localparam logic [1:0] DOWN_RIGHT = 2'b11;

    localparam int COL_W          = 12;
    localparam int DEF_DISP_COLS  = 800;
    localparam int DEF_GOAL_L_COL = 4;
    localparam int DEF_GOAL_R_COL = 796;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Player/ball-mover side signals of the game sequencer; slave is the sequencer,
// master is whatever drives buttons, ticks and the ball column.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic                       move_tick;
    logic                       start_btn;
    logic                       pause_btn;
    logic [pong_pkg::COL_W-1:0] ball_center_col;
    logic                       ball_load;
    logic                       ball_en;
    logic [1:0]                 serve_dir;
    logic [SCORE_W-1:0]         l_score;
    logic [SCORE_W-1:0]         r_score;
    logic                       point_pulse;
    logic                       game_over;
    logic                       winner;
    logic [2:0]                 state;

    modport master (
        output move_tick, start_btn, pause_btn, ball_center_col,
        input  ball_load, ball_en, serve_dir, l_score, r_score,
        input  point_pulse, game_over, winner, state
    );

    modport slave (
        input  move_tick, start_btn, pause_btn, ball_center_col,
        output ball_load, ball_en, serve_dir, l_score, r_score,
        output point_pulse, game_over, winner, state
    );
endinterface

// File: rtl/pong_edge_detect.sv
// Registered rising-edge detector: rise_o pulses for one cycle, one cycle after
// btn_i goes high.
module pong_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            prev_q <= btn_i;
            rise_q <= btn_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve timing, goal detection, scoring and winner, driving
// the ball mover's load/enable/direction controls.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int DISP_COLS   = DEF_DISP_COLS,
    parameter int GOAL_L_COL  = DEF_GOAL_L_COL,
    parameter int GOAL_R_COL  = DEF_GOAL_R_COL,
    parameter int SERVE_TICKS = 60,
    parameter int WIN_SCORE   = 11,
    parameter int SCORE_W     = 4
) (
    input  logic              clk,
    input  logic              rst,
    pong_game_ctrl_if.slave   io
);
    localparam int                 CNT_W    = $clog2(SERVE_TICKS + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_TICKS - 1);
    localparam logic [COL_W-1:0]   GOAL_L_C = COL_W'(GOAL_L_COL);
    localparam logic [COL_W-1:0]   GOAL_R_C = COL_W'(GOAL_R_COL);
    localparam logic [SCORE_W-1:0] WIN_C    = SCORE_W'(WIN_SCORE);

    if (SERVE_TICKS < 1 || WIN_SCORE > (2**SCORE_W) - 1 || GOAL_R_COL >= DISP_COLS) begin : g_param_check
        $error("pong_game_ctrl: illegal parameter combination");
    end

    logic start_rise;
    logic pause_rise;

    pong_edge_detect u_start_edge (.clk(clk), .rst(rst), .btn_i(io.start_btn), .rise_o(start_rise));
    pong_edge_detect u_pause_edge (.clk(clk), .rst(rst), .btn_i(io.pause_btn), .rise_o(pause_rise));

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] l_score_q, l_score_d;
    logic [SCORE_W-1:0] r_score_q, r_score_d;
    logic [1:0]         dir_q, dir_d;
    logic               winner_q, winner_d;
    logic               vtog_q, vtog_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               load_q, en_q, over_q, pulse_q;

    always_comb begin
        state_d   = state_q;
        l_score_d = l_score_q;
        r_score_d = r_score_q;
        dir_d     = dir_q;
        winner_d  = winner_q;
        vtog_d    = vtog_q;
        cnt_d     = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    l_score_d = '0;
                    r_score_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SERVE_WAIT;
                end
            end
            ST_SERVE_WAIT: begin
                if (io.move_tick) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PLAY: begin
                // The next serve heads toward whoever conceded, alternating vertically
                if (io.ball_center_col <= GOAL_L_C) begin
                    r_score_d = r_score_q + SCORE_W'(1);
                    vtog_d    = ~vtog_q;
                    dir_d     = {1'b0, ~vtog_q};
                    state_d   = ST_POINT;
                end else if (io.ball_center_col >= GOAL_R_C) begin
                    l_score_d = l_score_q + SCORE_W'(1);
                    vtog_d    = ~vtog_q;
                    dir_d     = {1'b1, ~vtog_q};
                    state_d   = ST_POINT;
                end else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_rise) state_d = ST_PLAY;
            end
            ST_POINT: begin
                if (l_score_q == WIN_C) begin
                    winner_d = 1'b0;
                    state_d  = ST_GAME_OVER;
                end else if (r_score_q == WIN_C) begin
                    winner_d = 1'b1;
                    state_d  = ST_GAME_OVER;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SERVE_WAIT;
                end
            end
            ST_GAME_OVER: begin
                if (start_rise) begin
                    l_score_d = '0;
                    r_score_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SERVE_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs are registered from the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            l_score_q <= '0;
            r_score_q <= '0;
            dir_q     <= UP_LEFT;
            winner_q  <= 1'b0;
            vtog_q    <= 1'b0;
            cnt_q     <= '0;
            load_q    <= 1'b1;
            en_q      <= 1'b0;
            over_q    <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            l_score_q <= l_score_d;
            r_score_q <= r_score_d;
            dir_q     <= dir_d;
            winner_q  <= winner_d;
            vtog_q    <= vtog_d;
            cnt_q     <= cnt_d;
            load_q    <= (state_d == ST_IDLE) || (state_d == ST_SERVE_WAIT) ||
                         (state_d == ST_POINT) || (state_d == ST_GAME_OVER);
            en_q      <= (state_d == ST_PLAY);
            over_q    <= (state_d == ST_GAME_OVER);
            pulse_q   <= (state_d == ST_POINT);
        end
    end

    assign io.state       = state_q;
    assign io.l_score     = l_score_q;
    assign io.r_score     = r_score_q;
    assign io.serve_dir   = dir_q;
    assign io.winner      = winner_q;
    assign io.ball_load   = load_q;
    assign io.ball_en     = en_q;
    assign io.game_over   = over_q;
    assign io.point_pulse = pulse_q;
endmodule
